// File: rtl/seq_det_param.sv
// Serial pattern detector with runtime-loadable pattern, overlap/non-overlap
// modes, Mealy match pulse, registered copy and saturating match counter.
module seq_det_param #(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
    parameter int                CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             seq_in,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             out,
    output logic             out_reg,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int HW = PAT_W - 1;
    localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [HW-1:0]    hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_reg_q, out_reg_d;

    logic accept;
    logic full;
    logic match;

    assign accept = reset & in_valid & ~pat_load;
    assign full   = (fill_q == FILL_FULL);
    assign match  = accept & full & ({hist_q, seq_in} == pat_q);

    always_comb begin
        pat_d     = pat_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        out_reg_d = match;

        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (accept) begin
            // Truncating cast keeps the newest PAT_W-1 samples, valid even when PAT_W=2.
            hist_d = HW'({hist_q, seq_in});
            if (match && !overlap) begin
                fill_d = '0;
            end else if (!full) begin
                fill_d = fill_q + FW'(1);
            end
            if (match && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pat_q     <= PATTERN;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            out_reg_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            out_reg_q <= out_reg_d;
        end
    end

    assign out       = match;
    assign out_reg   = out_reg_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed self-checking bench for seq_det_param: default instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation checks.
module tb_seq_det_param;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       seq_in;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       out;
    logic       out_reg;
    logic [7:0] match_cnt;
    logic       out2;
    logic       out_reg2;
    logic [1:0] match_cnt2;

    int checks   = 0;
    int failures = 0;

    seq_det_param dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .seq_in(seq_in),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .out(out), .out_reg(out_reg), .match_cnt(match_cnt)
    );

    seq_det_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .seq_in(seq_in),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .out(out2), .out_reg(out_reg2), .match_cnt(match_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change just after a rising edge; combinational out is sampled at the falling edge.
    task automatic apply(input logic rst, input logic v, input logic b,
                         input logic ov, input logic pl, input logic [3:0] pin);
        reset    = rst;
        in_valid = v;
        seq_in   = b;
        overlap  = ov;
        pat_load = pl;
        pat_in   = pin;
        @(negedge clock);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        tick();
    endtask

    task automatic test_reset;
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%b exp=0", out);
        end
        tick();
        checks++;
        if (out_reg !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_reg got=%b exp=0", out_reg);
        end
        checks++;
        if (match_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt);
        end
        checks++;
        if (match_cnt2 !== 2'd0) begin
            failures++;
            $display("FAIL reset_match_cnt2 got=%0d exp=0", match_cnt2);
        end
    endtask

    task automatic test_overlap;
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001001;
        logic [7:0] cnt = 8'd0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b1, s[6-i], 1'b1, 1'b0, 4'h0);
            checks++;
            if (out !== e[6-i]) begin
                failures++;
                $display("FAIL overlap_out[%0d] got=%b exp=%b", i + 1, out, e[6-i]);
            end
            tick();
            if (e[6-i]) cnt = cnt + 8'd1;
            checks++;
            if (out_reg !== e[6-i]) begin
                failures++;
                $display("FAIL overlap_out_reg[%0d] got=%b exp=%b", i + 1, out_reg, e[6-i]);
            end
            checks++;
            if (match_cnt !== cnt) begin
                failures++;
                $display("FAIL overlap_cnt[%0d] got=%0d exp=%0d", i + 1, match_cnt, cnt);
            end
        end
    endtask

    task automatic test_non_overlap;
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b1, s[6-i], 1'b0, 1'b0, 4'h0);
            checks++;
            if (out !== e[6-i]) begin
                failures++;
                $display("FAIL nonov_out[%0d] got=%b exp=%b", i + 1, out, e[6-i]);
            end
            tick();
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            failures++;
            $display("FAIL nonov_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_gaps;
        do_reset();
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        tick();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
            checks++;
            if (out !== 1'b0) begin
                failures++;
                $display("FAIL gap_out[%0d] got=%b exp=0", i, out);
            end
            tick();
        end
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL gap_out_third got=%b exp=0", out);
        end
        tick();
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checks++;
        if (out !== 1'b1) begin
            failures++;
            $display("FAIL gap_out_final got=%b exp=1", out);
        end
        tick();
        checks++;
        if (match_cnt !== 8'd1) begin
            failures++;
            $display("FAIL gap_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_pat_load;
        logic [5:0] e = 6'b000111;
        logic [7:0] cnt = 8'd0;
        do_reset();
        // A '1' offered during the load must be dropped, else the third 1 would match.
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL load_out got=%b exp=0", out);
        end
        tick();
        checks++;
        if (match_cnt !== 8'd0) begin
            failures++;
            $display("FAIL load_cnt_unchanged got=%0d exp=0", match_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
            checks++;
            if (out !== e[5-i]) begin
                failures++;
                $display("FAIL load_ones_out[%0d] got=%b exp=%b", i + 1, out, e[5-i]);
            end
            tick();
            if (e[5-i]) cnt = cnt + 8'd1;
        end
        checks++;
        if (match_cnt !== 8'd3) begin
            failures++;
            $display("FAIL load_cnt got=%0d exp=3", match_cnt);
        end
    endtask

    task automatic test_reset_discard;
        logic [2:0] pre = 3'b101;
        logic [3:0] post = 4'b1011;
        logic [3:0] e = 4'b0001;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, pre[2-i], 1'b1, 1'b0, 4'h0);
            tick();
        end
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_out got=%b exp=0", out);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, post[3-i], 1'b1, 1'b0, 4'h0);
            checks++;
            if (out !== e[3-i]) begin
                failures++;
                $display("FAIL rst_post_out[%0d] got=%b exp=%b", i + 1, out, e[3-i]);
            end
            tick();
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rst_post_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_saturate;
        logic [12:0] s = 13'b1011011011011;
        logic [12:0] e = 13'b0001001001001;
        logic [7:0] cnt = 8'd0;
        logic [1:0] cnt2 = 2'd0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(1'b1, 1'b1, s[12-i], 1'b1, 1'b0, 4'h0);
            checks++;
            if (out2 !== e[12-i]) begin
                failures++;
                $display("FAIL sat_out[%0d] got=%b exp=%b", i + 1, out2, e[12-i]);
            end
            tick();
            if (e[12-i]) begin
                cnt = cnt + 8'd1;
                if (cnt2 != 2'd3) cnt2 = cnt2 + 2'd1;
            end
            checks++;
            if (match_cnt2 !== cnt2) begin
                failures++;
                $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i + 1, match_cnt2, cnt2);
            end
        end
        checks++;
        if (match_cnt !== 8'd4) begin
            failures++;
            $display("FAIL sat_cnt_wide got=%0d exp=4", match_cnt);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        tick();
        checks++;
        if (match_cnt2 !== 2'd3) begin
            failures++;
            $display("FAIL sat_cnt2_hold got=%0d exp=3", match_cnt2);
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        seq_in   = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = 4'h0;
        tick();
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_pat_load();
        test_reset_discard();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
